// File: rtl/mem_map_pkg.sv
// rtl/mem_map_pkg.sv - MMIO offsets, STATUS bit positions and region decode enum for mem_responder
package mem_map_pkg;

  localparam logic [3:0] OFS_TXDATA = 4'h0;
  localparam logic [3:0] OFS_STATUS = 4'h4;
  localparam logic [3:0] OFS_CYCLE  = 4'h8;
  localparam logic [3:0] OFS_HALT   = 4'hC;

  localparam int ST_EMPTY    = 0;
  localparam int ST_FULL     = 1;
  localparam int ST_OVERFLOW = 2;
  localparam int ST_HALT     = 3;

  typedef enum logic [1:0] {RGN_RAM, RGN_MMIO, RGN_NONE} region_e;

endpackage

// File: rtl/tx_fifo.sv
// rtl/tx_fifo.sv - byte FIFO feeding the TX drain port; no push-to-head bypass
module tx_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] head,
  output logic       full,
  output logic       empty
);

  localparam int PW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (PW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? 8'h00 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + {{PW{1'b0}}, do_push} - {{PW{1'b0}}, do_pop};
    end
  end

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - RAM + MMIO responder for the core bus; MEM_RESPONDER_CYCLE_EN builds the CYCLE counter
module mem_responder
  import mem_map_pkg::*;
#(
  parameter int          MEM_WORDS  = 4096,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] address,
  input  logic [31:0] data_in,
  input  logic        we,
  output logic [31:0] data_out,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        halt,
  output logic [31:0] halt_code,
  output logic        fault
);

  localparam int          AW        = $clog2(MEM_WORDS);
  localparam logic [32:0] RAM_LIMIT = 33'(MEM_WORDS) * 33'd4;

  logic [31:0] ram [MEM_WORDS];
  region_e     region;
  logic [AW-1:0] ram_idx;
  logic [3:0]  reg_ofs;
  logic        overflow;
  logic        fifo_full;
  logic        fifo_empty;
  logic        tx_pop;
  logic        tx_write;
  logic [31:0] cycle_count;
  logic [31:0] status_word;

  always_comb begin
    region = RGN_NONE;
    if ({1'b0, address} < RAM_LIMIT) begin
      region = RGN_RAM;
    end else if (address[31:4] == MMIO_BASE[31:4]) begin
      region = RGN_MMIO;
    end
  end

  assign ram_idx = address[AW+1:2];
  assign reg_ofs = {address[3:2], 2'b00};

  assign tx_pop   = tx_valid && tx_ready;
  assign tx_write = we && !halt && (region == RGN_MMIO) && (reg_ofs == OFS_TXDATA);
  assign tx_valid = !fifo_empty;

  tx_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (tx_write),
    .push_data (data_in[7:0]),
    .pop       (tx_pop),
    .head      (tx_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

`ifdef MEM_RESPONDER_CYCLE_EN
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cycle_count <= '0;
    end else begin
      cycle_count <= cycle_count + 32'd1;
    end
  end
`else
  assign cycle_count = '0;
`endif

  always_comb begin
    status_word              = '0;
    status_word[ST_EMPTY]    = fifo_empty;
    status_word[ST_FULL]     = fifo_full;
    status_word[ST_OVERFLOW] = overflow;
    status_word[ST_HALT]     = halt;
  end

  always_comb begin
    data_out = '0;
    case (region)
      RGN_RAM: data_out = ram[ram_idx];
      RGN_MMIO: begin
        case (reg_ofs)
          OFS_TXDATA: data_out = {30'b0, fifo_full, fifo_empty};
          OFS_STATUS: data_out = status_word;
          OFS_CYCLE:  data_out = cycle_count;
          OFS_HALT:   data_out = halt_code;
          default:    data_out = '0;
        endcase
      end
      default: data_out = '0;
    endcase
  end

  // RAM contents survive reset; only the write is blocked during it.
  always_ff @(posedge clk) begin
    if (resetn && we && !halt && (region == RGN_RAM)) begin
      ram[ram_idx] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      halt      <= 1'b0;
      halt_code <= '0;
      overflow  <= 1'b0;
      fault     <= 1'b0;
    end else begin
      if (region == RGN_NONE) begin
        fault <= 1'b1;
      end
      if (we && !halt && (region == RGN_MMIO) && (reg_ofs == OFS_HALT)) begin
        halt      <= 1'b1;
        halt_code <= data_in;
      end
      if (we && (region == RGN_MMIO) && (reg_ofs == OFS_STATUS) && data_in[ST_OVERFLOW]) begin
        overflow <= 1'b0;
      end else if (tx_write && fifo_full && !tx_pop) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - directed self-checking bench for mem_responder
module tb_mem_responder;

  localparam logic [31:0] MMIO      = 32'hFFFF_0000;
  localparam logic [31:0] A_TXDATA  = MMIO + 32'h0;
  localparam logic [31:0] A_STATUS  = MMIO + 32'h4;
  localparam logic [31:0] A_CYCLE   = MMIO + 32'h8;
  localparam logic [31:0] A_HALT    = MMIO + 32'hC;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] address;
  logic [31:0] data_in;
  logic        we;
  logic [31:0] data_out;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        halt;
  logic [31:0] halt_code;
  logic        fault;

  int n_cmp = 0;
  int n_err = 0;

  mem_responder #(
    .MEM_WORDS  (4096),
    .FIFO_DEPTH (8),
    .MMIO_BASE  (32'hFFFF_0000)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .address   (address),
    .data_in   (data_in),
    .we        (we),
    .data_out  (data_out),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .halt      (halt),
    .halt_code (halt_code),
    .fault     (fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus(input logic [31:0] a, input logic [31:0] d, input logic w);
    address = a;
    data_in = d;
    we      = w;
  endtask

  task automatic rd(input logic [31:0] a);
    bus(a, 32'h0, 1'b0);
    #1;
  endtask

  initial begin
    logic [7:0]  exp_bytes [8];
    logic [31:0] exp_cycle;

    resetn   = 1'b0;
    tx_ready = 1'b0;
    bus(32'h0, 32'h0, 1'b0);
    tick();
    tick();
    chk("rst_tx_valid", 32'(tx_valid), 32'h0);
    chk("rst_tx_data", 32'(tx_data), 32'h0);
    chk("rst_halt", 32'(halt), 32'h0);
    chk("rst_halt_code", halt_code, 32'h0);
    chk("rst_fault", 32'(fault), 32'h0);
    resetn = 1'b1;
    rd(A_STATUS);
    chk("rst_status", data_out, 32'h1);

    // RAM write then read, including an unaligned address in the same word
    bus(32'h100, 32'hDEAD_BEEF, 1'b1);
    tick();
    rd(32'h100);
    chk("ram_rd_100", data_out, 32'hDEAD_BEEF);
    rd(32'h102);
    chk("ram_rd_102", data_out, 32'hDEAD_BEEF);

    // overflow: nine pushes into an 8-deep FIFO with no drain
    for (int i = 0; i < 9; i++) begin
      bus(A_TXDATA, 32'h41 + 32'(i), 1'b1);
      tick();
    end
    rd(A_STATUS);
    chk("ovf_status", data_out, 32'h6);
    rd(A_TXDATA);
    chk("ovf_txdata_rd", data_out, 32'h2);
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("drain_valid", 32'(tx_valid), 32'h1);
      chk("drain_byte", 32'(tx_data), 32'h41 + 32'(i));
      tick();
    end
    chk("drain_empty", 32'(tx_valid), 32'h0);
    tx_ready = 1'b0;
    bus(A_STATUS, 32'h4, 1'b1);
    tick();
    rd(A_STATUS);
    chk("ovf_clear", data_out, 32'h1);

    // push into a full FIFO while it pops: no overflow, count unchanged
    for (int i = 0; i < 8; i++) begin
      bus(A_TXDATA, 32'h61 + 32'(i), 1'b1);
      tick();
    end
    rd(A_STATUS);
    chk("full_status", data_out, 32'h2);
    tx_ready = 1'b1;
    bus(A_TXDATA, 32'h5A, 1'b1);
    tick();
    rd(A_STATUS);
    chk("pushpop_status", data_out, 32'h2);
    exp_bytes = '{8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67, 8'h68, 8'h5A};
    for (int i = 0; i < 8; i++) begin
      chk("pp_byte", 32'(tx_data), 32'(exp_bytes[i]));
      tick();
    end
    chk("pp_empty", 32'(tx_valid), 32'h0);
    tx_ready = 1'b0;

    // reset with three bytes queued, then CYCLE from reset release
    for (int i = 0; i < 3; i++) begin
      bus(A_TXDATA, 32'h71 + 32'(i), 1'b1);
      tick();
    end
    bus(32'h0, 32'h0, 1'b0);
    chk("q3_valid", 32'(tx_valid), 32'h1);
    resetn   = 1'b0;
    tx_ready = 1'b1;
    bus(A_TXDATA, 32'h99, 1'b1);
    tick();
    resetn   = 1'b0;
    tx_ready = 1'b0;
    resetn   = 1'b1;
    chk("rst_mid_valid", 32'(tx_valid), 32'h0);
    chk("rst_mid_data", 32'(tx_data), 32'h0);
    rd(A_STATUS);
    chk("rst_mid_status", data_out, 32'h1);
    rd(A_CYCLE);
    chk("cycle_0", data_out, 32'h0);
    for (int i = 0; i < 5; i++) tick();
`ifdef MEM_RESPONDER_CYCLE_EN
    exp_cycle = 32'd5;
`else
    exp_cycle = 32'd0;
`endif
    chk("cycle_5", data_out, exp_cycle);
    rd(32'h100);
    chk("ram_keep", data_out, 32'hDEAD_BEEF);

    // unmapped access
    rd(32'h8000_0000);
    chk("unmap_rd", data_out, 32'h0);
    chk("fault_pre", 32'(fault), 32'h0);
    tick();
    chk("fault_set", 32'(fault), 32'h1);
    rd(32'h100);
    tick();
    chk("fault_sticky", 32'(fault), 32'h1);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    chk("fault_rst", 32'(fault), 32'h0);
    rd(32'h4000);
    tick();
    chk("fault_ram_edge", 32'(fault), 32'h1);

    // halt: first code wins, later RAM and TXDATA writes ignored
    bus(32'h0, 32'h1111, 1'b1);
    tick();
    bus(A_HALT, 32'h2A, 1'b1);
    tick();
    bus(A_HALT, 32'h3, 1'b1);
    tick();
    bus(32'h0, 32'h1234, 1'b1);
    tick();
    bus(A_TXDATA, 32'h55, 1'b1);
    tick();
    bus(32'h0, 32'h0, 1'b0);
    chk("halt_flag", 32'(halt), 32'h1);
    chk("halt_code", halt_code, 32'h2A);
    chk("halt_no_tx", 32'(tx_valid), 32'h0);
    rd(A_HALT);
    chk("halt_rd", data_out, 32'h2A);
    rd(32'h0);
    chk("halt_ram", data_out, 32'h1111);
    rd(A_STATUS);
    chk("halt_status", data_out, 32'h9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the core's single-port bus. It serves instruction fetches, loads and stores from a word-organised RAM, and decodes a small MMIO window. The window holds a byte-output FIFO with a valid/ready drain port, a status register, a cycle counter and a halt register. It sits between the core and the testbench/top level, as the far end of the core's address/data/we interface.

## Interface
Parameters:
- MEM_WORDS, 4096: RAM depth in 32-bit words; power of two.
- FIFO_DEPTH, 8: TX FIFO entries; power of two, ≥2.
- MMIO_BASE, 32'hFFFF_0000: base of the 16-byte MMIO window.

Ports:
- clk  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- address  in  32  byte address from core
- data_in  in  32  write data from core; always a full word, since the core performs read-modify-write for sub-word stores
- we  in  1  write enable, sampled at posedge clk
- data_out  out  32  read data to core; combinational from address
- tx_valid  out  1  FIFO head valid
- tx_data  out  8  FIFO head byte
- tx_ready  in  1  consumer accepts head
- halt  out  1  sticky halt flag
- halt_code  out  32  value written to HALT
- fault  out  1  sticky: access outside RAM and MMIO

## Operation
- Decode:
  - RAM hit when address < MEM_WORDS*4. Word index is address[log2(MEM_WORDS)+1:2]; address[1:0] is ignored.
  - MMIO hit when address[31:4] == MMIO_BASE[31:4]. Register select is address[3:2]; address[1:0] is ignored.
  - Any other address is unmapped.
- Reads are asynchronous: data_out is valid in the same cycle as address, because the core latches fetch and load data at the next edge.
- RAM writes: on posedge with we=1, the word is fully replaced.
- MMIO offset 0x0 TXDATA:
  - Write pushes data_in[7:0] if the FIFO is not full.
  - If the FIFO is full and no pop occurs that cycle, the byte is dropped and overflow is set.
  - Read returns {30'b0, full, empty}.
- MMIO offset 0x4 STATUS:
  - Read returns {28'b0, halt, overflow, full, empty}.
  - Write with data_in[2]=1 clears overflow. All other bits are ignored.
- MMIO offset 0x8 CYCLE:
  - Read returns a free-running 32-bit counter that increments every cycle out of reset and wraps 0xFFFF_FFFF→0.
  - Writes are ignored.
- MMIO offset 0xC HALT:
  - Write sets halt=1 and halt_code=data_in.
  - Read returns halt_code.
  - Once halt=1, further HALT writes are ignored (first code wins).
- After halt=1, RAM and TXDATA writes are ignored. The FIFO continues to drain and reads continue to work.
- Unmapped access: reads return 0; writes are ignored; fault is set on the cycle of any unmapped access with we=1, or with we=0.
- FIFO:
  - Pop on tx_valid && tx_ready. tx_valid = !empty; tx_data = head.
  - Simultaneous push and pop when full: both occur and the count is unchanged.
  - Simultaneous push and pop when empty: the pushed byte is not visible until the next cycle (no bypass).
  - Pointers wrap modulo FIFO_DEPTH. Count is log2(FIFO_DEPTH)+1 bits wide.

## Timing
- Read latency 0 cycles (combinational). Write takes effect at the edge where we=1; a read of the same address in the next cycle returns the new value.
- TX latency: a push at edge N makes tx_valid=1 from N+1.
- Reset (resetn=0 at posedge) takes priority over all events, including a write in the same cycle. After reset:
  - FIFO empty, tx_valid=0, tx_data=0.
  - overflow=0, fault=0, halt=0, halt_code=0, CYCLE=0.
  - RAM contents are not reset.
- Reset mid-drain discards all FIFO contents; a handshake in the reset cycle is not counted.

## Configuration
- MEM_RESPONDER_CYCLE_EN defined: CYCLE counter is built as described.
- Not defined: no counter flops; CYCLE reads 0.

## Structure
- Package mem_map_pkg:
  - MMIO offset constants (TXDATA=0x0, STATUS=0x4, CYCLE=0x8, HALT=0xC).
  - STATUS bit positions.
  - Region-decode enum {RGN_RAM, RGN_MMIO, RGN_NONE}.
- Sub-module tx_fifo (parameter DEPTH; push/pop/full/empty/head). Decode, RAM, registers and counter stay in the top level.

## Test plan
- Write 0xDEADBEEF to 0x100, then read 0x100 next cycle → data_out=0xDEADBEEF. Read 0x102 → same word.
- Hold tx_ready=0 and write TXDATA 9 times (bytes 0x41..0x49) with FIFO_DEPTH=8 → full=1, overflow=1, 0x49 dropped. Raise tx_ready → 0x41..0x48 drained in order, then tx_valid=0.
- FIFO full with tx_ready=1, plus a TXDATA write of 0x5A in the same cycle → no overflow, count stays 8, 0x5A eventually emitted last.
- Write HALT=0x2A, then HALT=0x3, then RAM 0x0=0x1234 → halt=1, halt_code=0x2A, RAM[0] unchanged.
- Read 0x8000_0000 → data_out=0, fault=1. Then reset → fault=0, CYCLE read immediately after reset release = 0, and = 5 five cycles later (macro defined).
- Reset asserted with 3 bytes queued → tx_valid=0 the cycle after reset, STATUS reads 0x1.
